// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared data/address widths and the store buffer entry type
package cpu_mem_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DMEM_IDX_W = 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: finds the youngest queued store whose low address bits match the load
module sb_fwd_match
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int MATCH_W = DMEM_IDX_W
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [MATCH_W-1:0]       ld_addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);
    localparam int PW = $clog2(DEPTH);

    logic unused_addr;

    always_comb begin
        hit = 1'b0;
        data = '0;
        unused_addr = 1'b0;
        // walk from tail-1 back toward head so the first match is the youngest store
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!hit && (PW + 1)'(i) < count && entries[head + PW'(i)].valid
                && entries[head + PW'(i)].addr[MATCH_W-1:0] == ld_addr) begin
                hit = 1'b1;
                data = entries[head + PW'(i)].data;
            end
            unused_addr = unused_addr ^ (^entries[i].addr);
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order posted-store FIFO in front of dmem with load forwarding
// and starvation-forced drains; sole master of the dmem port
module store_buffer
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int MATCH_W = DMEM_IDX_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [15:0]            st_addr,
    input  logic [15:0]            st_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [15:0]            ld_addr,
    output logic [15:0]            ld_data,
    output logic                   ld_fwd,
    output logic [15:0]            mem_addr,
    output logic [15:0]            mem_write_data,
    output logic                   mem_write,
    output logic                   mem_read,
    input  logic [15:0]            mem_read_data,
    output logic                   sb_empty,
    output logic [$clog2(DEPTH):0] sb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    sb_entry_t         entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW:0]       count;
    logic [SW-1:0]     starve;
    logic              force_drain;
    logic              drain;
    logic              accept;
    logic              load_svc;
    logic              hit;
    logic [DATA_W-1:0] fwd_data;

    assign sb_empty = (count == '0);
    assign sb_count = count;
    assign st_ready = (count != (PW + 1)'(DEPTH));
    assign accept = st_valid && st_ready;
    assign force_drain = !sb_empty && (starve == SW'(STARVE_LIMIT - 1));
    assign drain = !sb_empty && (!ld_valid || force_drain);
    assign load_svc = ld_valid && !force_drain;

    assign ld_ready = !force_drain;
    assign ld_fwd = load_svc && hit;
    assign ld_data = hit ? fwd_data : mem_read_data;
    assign mem_write = drain;
    assign mem_read = load_svc;
    assign mem_addr = drain ? entries[head].addr : load_svc ? ld_addr : '0;
    assign mem_write_data = drain ? entries[head].data : '0;

    sb_fwd_match #(
        .DEPTH   (DEPTH),
        .MATCH_W (MATCH_W)
    ) u_match (
        .entries (entries),
        .head    (head),
        .count   (count),
        .ld_addr (ld_addr[MATCH_W-1:0]),
        .hit     (hit),
        .data    (fwd_data)
    );

    // a non-empty buffer that is not draining must be blocked by a serviced load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            starve <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else begin
            if (accept) begin
                entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
                tail <= tail + 1'b1;
            end
            if (drain) begin
                entries[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            count <= count + (PW + 1)'(accept) - (PW + 1)'(drain);
            starve <= (drain || sb_empty) ? '0 : starve + 1'b1;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed plus randomized checks of store_buffer against a queue-based model
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [15:0] st_addr = '0;
    logic [15:0] st_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data;
    logic        ld_fwd;
    logic [15:0] mem_addr;
    logic [15:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_read_data;
    logic        sb_empty;
    logic [2:0]  sb_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] dmem [256];
    logic [15:0] ref_mem [256];

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } st_t;

    st_t         q[$];
    int          starve = 0;
    int          m_n = 0;
    logic        m_frc, m_svc, m_hit, e_drain, e_acc;
    logic [15:0] m_fd;

    store_buffer #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .MATCH_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_fwd         (ld_fwd),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data),
        .sb_empty       (sb_empty),
        .sb_count       (sb_count)
    );

    always #5 clk = ~clk;

    assign mem_read_data = dmem[mem_addr[7:0]];

    always @(posedge clk) if (mem_write) dmem[mem_addr[7:0]] <= mem_write_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: outputs follow from the queue contents, starvation count and current inputs
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_st_ready", 32'(st_ready), 1);
            chk("rst_sb_empty", 32'(sb_empty), 1);
            chk("rst_sb_count", 32'(sb_count), 0);
            chk("rst_mem_write", 32'(mem_write), 0);
            chk("rst_ld_fwd", 32'(ld_fwd), 0);
            chk("rst_ld_ready", 32'(ld_ready), 1);
        end else begin
            m_n = q.size();
            m_frc = (m_n != 0) && (starve == LIMIT - 1);
            m_svc = ld_valid && !m_frc;
            m_hit = 1'b0;
            m_fd = '0;
            for (int i = m_n - 1; i >= 0; i--) begin
                if (!m_hit && q[i].a[7:0] == ld_addr[7:0]) begin
                    m_hit = 1'b1;
                    m_fd = q[i].d;
                end
            end
            e_drain = (m_n != 0) && (!ld_valid || m_frc);
            e_acc = st_valid && (m_n != DEPTH);
            chk("st_ready", 32'(st_ready), 32'(m_n != DEPTH));
            chk("sb_empty", 32'(sb_empty), 32'(m_n == 0));
            chk("sb_count", 32'(sb_count), m_n);
            chk("ld_ready", 32'(ld_ready), 32'(!m_frc));
            chk("ld_fwd", 32'(ld_fwd), 32'(m_svc && m_hit));
            chk("mem_write", 32'(mem_write), 32'(e_drain));
            chk("mem_read", 32'(mem_read), 32'(m_svc));
            chk("mem_addr", 32'(mem_addr), 32'(e_drain ? q[0].a : m_svc ? ld_addr : 16'h0));
            if (e_drain) chk("mem_write_data", 32'(mem_write_data), 32'(q[0].d));
            if (m_svc) chk("ld_data", 32'(ld_data), 32'(m_hit ? m_fd : ref_mem[ld_addr[7:0]]));
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            starve = 0;
        end else begin
            if (e_drain) begin
                ref_mem[q[0].a[7:0]] = q[0].d;
                q.delete(0);
            end
            starve = (e_drain || m_n == 0) ? 0 : starve + 1;
            if (e_acc) q.push_back('{a: st_addr, d: st_data});
        end
    end

    task automatic drive(input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                         input logic lv, input logic [15:0] la);
        st_valid = sv;
        st_addr = sa;
        st_data = sd;
        ld_valid = lv;
        ld_addr = la;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all(input string nm);
        drive(0, 0, 0, 0, 0);
        for (int c = 0; c < 20 && !sb_empty; c++) tick();
        chk(nm, 32'(sb_empty), 1);
    endtask

    function automatic logic [15:0] raddr();
        return {8'($urandom), 5'b0, 3'($urandom)};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        int ac;
        int sent;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = '0;
            ref_mem[i] = '0;
        end
        e_drain = 1'b0;
        e_acc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(sb_count), 0);
        rst_n = 1'b1;

        // three stores, no loads: in-order writes, last one to 0x10 wins
        drive(1, 16'h0010, 16'hAAAA, 0, 0);
        tick();
        drive(1, 16'h0011, 16'hBBBB, 0, 0);
        tick();
        drive(1, 16'h0010, 16'hCCCC, 0, 0);
        tick();
        chk("t1_count_one", 32'(sb_count), 1);
        drive(0, 0, 0, 0, 0);
        tick();
        chk("t1_count_zero", 32'(sb_count), 0);
        chk("t1_dmem10", 32'(dmem[8'h10]), 32'hCCCC);
        chk("t1_dmem11", 32'(dmem[8'h11]), 32'hBBBB);

        // fill under continuous loads; fifth store waits for the forced drain
        fc = -1;
        ac = -1;
        sent = 0;
        for (int c = 0; c < 30 && ac < 0; c++) begin
            drive(sent < 5, 16'(16'h0050 + sent), 16'(16'h0100 + sent), 1, 16'h0080);
            #1;
            if (c == 4) chk("t2_full_ready", 32'(st_ready), 0);
            if (!ld_ready && fc < 0) fc = c;
            if (sent < 5 && st_ready) begin
                if (sent == 4) ac = c;
                sent++;
            end
            tick();
        end
        chk("t2_force_cycle", fc, 8);
        chk("t2_fifth_accept", ac, 9);
        drain_all("t2_drained");

        // forwarding on low 8 bits, then the same data from dmem after drain
        drive(1, 16'h0020, 16'h1234, 0, 0);
        tick();
        drive(0, 0, 0, 1, 16'h0120);
        #1;
        chk("t3_fwd", 32'(ld_fwd), 1);
        chk("t3_fwd_data", 32'(ld_data), 32'h1234);
        tick();
        drain_all("t3_drained");
        drive(0, 0, 0, 1, 16'h0020);
        #1;
        chk("t3_mem_fwd", 32'(ld_fwd), 0);
        chk("t3_mem_data", 32'(ld_data), 32'h1234);
        tick();

        // a store accepted in the load's own cycle is not visible to it
        drive(1, 16'h0030, 16'h5555, 1, 16'h0030);
        #1;
        chk("t4_same_data", 32'(ld_data), 0);
        chk("t4_same_fwd", 32'(ld_fwd), 0);
        tick();
        drive(0, 0, 0, 1, 16'h0030);
        #1;
        chk("t4_next_data", 32'(ld_data), 32'h5555);
        chk("t4_next_fwd", 32'(ld_fwd), 1);
        tick();
        drain_all("t4_drained");

        // starvation with two queued stores: eighth blocked cycle is forced
        for (int c = 0; c < 10; c++) begin
            drive(c < 2, 16'(16'h0060 + c), 16'(16'h0200 + c), 1, 16'h0090);
            #1;
            if (c == 8) begin
                chk("t5_force_ready", 32'(ld_ready), 0);
                chk("t5_force_write", 32'(mem_write), 1);
            end
            if (c == 9) chk("t5_after_ready", 32'(ld_ready), 1);
            tick();
        end
        drain_all("t5_drained");

        // asynchronous reset in the first drain cycle with three queued stores
        for (int c = 0; c < 3; c++) begin
            drive(1, 16'(16'h0040 + c), 16'(16'h0300 + c), 1, 16'h00A0);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #1;
        chk("t6_pre_write", 32'(mem_write), 1);
        chk("t6_pre_count", 32'(sb_count), 3);
        rst_n = 1'b0;
        #1;
        chk("t6_async_write", 32'(mem_write), 0);
        chk("t6_async_count", 32'(sb_count), 0);
        chk("t6_async_empty", 32'(sb_empty), 1);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_dmem40", 32'(dmem[8'h40]), 0);
        chk("t6_dmem41", 32'(dmem[8'h41]), 0);
        chk("t6_dmem42", 32'(dmem[8'h42]), 0);

        // randomized traffic, alternating light and heavy load phases
        for (int c = 0; c < 3000; c++) begin
            automatic int pct = ((c / 200) % 2) != 0 ? 92 : 45;
            drive($urandom_range(0, 99) < 60, raddr(), 16'($urandom),
                  $urandom_range(0, 99) < pct, raddr());
            tick();
        end
        drain_all("final_drained");
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
